// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: streams a contiguous run of 8-bit pixels from the single-port pixel RAM
// onto a valid/ready byte stream. A 2-entry skid FIFO absorbs the RAM's one-cycle read latency,
// so backpressure from the sink never drops or duplicates a pixel.
// Optional feature: define PIXEL_STREAM_READER_CHECKSUM_EN to add a 16-bit running sum of every
// pixel accepted by the sink on output port checksum.
module pixel_stream_reader #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [7:0]        ram_readdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              first_q, first_d;
    logic              inflight_q;
    logic              inflight_sop_q, inflight_eop_q;
    logic              zero_done_q;

    // FIFO entry layout: {sop, eop, data}
    logic [9:0]        fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic              issue;
    logic              pop;
    logic              push;
    logic              accept_start;
    logic              drain_done;
    logic              zero_start;
    logic [2:0]        occupancy;

    assign pop  = out_valid & out_ready;
    assign push = inflight_q;

    // Slots committed for the next cycle: stored entries plus the read in flight, minus a pop.
    assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);

    // Next-state logic: launch, read issue and drain completion
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        first_d      = first_q;
        issue        = 1'b0;
        accept_start = 1'b0;
        drain_done   = 1'b0;
        zero_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (length != '0) begin
                        state_d     = StRun;
                        addr_d      = base;
                        remaining_d = length;
                        first_d     = 1'b1;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            StRun: begin
                if (remaining_q != '0 && occupancy < 3'd2) begin
                    issue       = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    first_d     = 1'b0;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (count_q == 2'd0 && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            remaining_q    <= '0;
            first_q        <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_sop_q <= 1'b0;
            inflight_eop_q <= 1'b0;
            zero_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            first_q        <= first_d;
            inflight_q     <= issue;
            inflight_sop_q <= issue & first_q;
            inflight_eop_q <= issue & (remaining_q == LEN_W'(1));
            zero_done_q    <= zero_start;
        end
    end

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Skid FIFO storage; the read in flight lands here one cycle after its issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {inflight_sop_q, inflight_eop_q, ram_readdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running sum of accepted pixels, cleared on every accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (accept_start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + {8'd0, out_data};
        end
    end

    assign checksum = sum_q;
`endif

    assign busy           = (state_q != StIdle);
    assign done           = zero_done_q | drain_done;
    assign ram_address    = addr_q;
    assign ram_chipselect = issue;
    assign ram_write      = 1'b0;
    assign ram_clken      = 1'b1;
    assign out_valid      = (count_q != 2'd0);
    assign out_data       = fifo_q[rd_ptr_q][7:0];
    assign out_eop        = fifo_q[rd_ptr_q][8];
    assign out_sop        = fifo_q[rd_ptr_q][9];

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Bench for pixel_stream_reader: behavioural RAM, scoreboard queues for issued addresses and
// streamed pixels, a vector table of transfers plus hand-written corner sequences.
module tb_pixel_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [14:0] base = '0;
    logic [15:0] length = '0;
    logic        busy, done;
    logic [14:0] ram_address;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [7:0]  ram_readdata = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sop, out_eop;
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    pixel_stream_reader #(.ADDR_W(15), .LEN_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base           (base),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop)
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32768];

    // Pixel RAM: data valid the cycle after a read issue
    always @(posedge clk) begin
        if (ram_chipselect) ram_readdata <= mem[ram_address];
    end

    int          total = 0;
    int          bad = 0;
    logic [9:0]  exp_pix [$];
    logic [14:0] exp_addr [$];
    int          issued = 0;
    int          popped = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          mode = 0;
    logic [15:0] exp_sum = '0;
    int          d0;

    typedef struct {
        logic [14:0] base;
        int          len;
        int          mode;
        int          exp_done;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        if (reset) begin
            exp_pix.delete();
            exp_addr.delete();
            issued = 0;
            popped = 0;
            return;
        end
        if (out_valid) begin
            if (exp_pix.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                check("pixel", {out_sop, out_eop, out_data}, exp_pix[0]);
                if (out_ready) begin
                    void'(exp_pix.pop_front());
                    popped++;
                end
            end
        end
        if (ram_chipselect) begin
            check("room_for_issue", (issued - popped) < 2, 1);
            if (exp_addr.size() == 0) check("unexpected_issue", 1, 0);
            else check("issue_addr", ram_address, exp_addr.pop_front());
            issued++;
        end
        if (done) done_cnt++;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic launch(input logic [14:0] b, input int l, input bit push);
        base   = b;
        length = 16'(l);
        start  = 1'b1;
        if (push) begin
            exp_sum = '0;
            for (int i = 0; i < l; i++) begin
                automatic logic [14:0] a = b + 15'(i);
                exp_addr.push_back(a);
                exp_pix.push_back({i == 0, i == l - 1, mem[a]});
                exp_sum = exp_sum + {8'd0, mem[a]};
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_cnt, input int budget);
        int n = 0;
        while (done_cnt == base_cnt && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("done_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'(i * 7 + (i >> 8) + 1);
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        mem[16'h0103] = 8'h44;

        vecs[0] = '{base: 15'h0100, len: 4,     mode: 0, exp_done: 1};
        vecs[1] = '{base: 15'h7FFE, len: 4,     mode: 0, exp_done: 1};
        vecs[2] = '{base: 15'h0200, len: 16,    mode: 1, exp_done: 1};
        vecs[3] = '{base: 15'h0300, len: 16,    mode: 2, exp_done: 1};
        vecs[4] = '{base: 15'h1234, len: 1,     mode: 0, exp_done: 1};
        vecs[5] = '{base: 15'h0000, len: 32768, mode: 0, exp_done: 1};

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sop", out_sop, 0);
        check("rst_eop", out_eop, 0);
        check("rst_data", out_data, 0);
        check("rst_cs", ram_chipselect, 0);
        check("rst_addr", ram_address, 0);
        check("ram_write", ram_write, 0);
        check("ram_clken", ram_clken, 1);
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        reset = 1'b0;
        tick();

        // Basic run with latency checks
        mode = 0;
        d0 = done_cnt;
        launch(15'h0100, 4, 1);
        check("lat_busy", busy, 1);
        check("lat_cs", ram_chipselect, 1);
        check("lat_addr", ram_address, 15'h0100);
        check("lat_valid_c1", out_valid, 0);
        tick();
        check("lat_valid_c2", out_valid, 0);
        tick();
        check("lat_valid_c3", out_valid, 1);
        check("lat_first", {out_sop, out_data}, {1'b1, 8'h11});
        wait_done(d0, 100);
        repeat (3) tick();
        check("basic_done_count", done_cnt - d0, 1);
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
        check("basic_checksum", checksum, 16'h00AA);
`endif

        // Zero length: done the next cycle, no reads
        d0 = done_cnt;
        launch(15'h0040, 0, 1);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        tick();
        check("zero_done_clear", done, 0);
        check("zero_done_count", done_cnt - d0, 1);
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
        check("zero_checksum", checksum, 0);
`endif
        repeat (3) tick();

        // Table of transfers
        for (int v = 0; v < 6; v++) begin
            mode = vecs[v].mode;
            d0 = done_cnt;
            launch(vecs[v].base, vecs[v].len, 1);
            wait_done(d0, vecs[v].len * 8 + 100);
            repeat (4) tick();
            check("done_count", done_cnt - d0, vecs[v].exp_done);
            check("pixels_left", exp_pix.size(), 0);
            check("issues_left", exp_addr.size(), 0);
            check("busy_after", busy, 0);
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
            check("checksum", checksum, exp_sum);
`endif
        end

        // Start while busy is ignored
        mode = 0;
        d0 = done_cnt;
        launch(15'h0100, 4, 1);
        tick();
        base   = 15'h0200;
        length = 16'd8;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0, 100);
        repeat (8) tick();
        check("busy_start_done_count", done_cnt - d0, 1);
        check("busy_start_pixels_left", exp_pix.size(), 0);
        check("busy_start_busy", busy, 0);

        // Reset mid-transfer with the FIFO full
        mode = 3;
        tick();
        d0 = done_cnt;
        launch(15'h0500, 16, 1);
        repeat (5) tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_fill", issued - popped, 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_tags", {out_sop, out_eop}, 0);
        check("mid_rst_cs", ram_chipselect, 0);
        check("mid_rst_addr", ram_address, 0);
        check("mid_rst_done", done, 0);
        tick();
        tick();
        reset = 1'b0;
        mode = 0;
        repeat (4) tick();
        check("post_rst_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        launch(15'h0600, 5, 1);
        wait_done(d0, 100);
        repeat (3) tick();
        check("post_rst_done_count", done_cnt - d0, 1);
        check("post_rst_pixels_left", exp_pix.size(), 0);
`ifdef PIXEL_STREAM_READER_CHECKSUM_EN
        check("post_rst_checksum", checksum, exp_sum);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
